// File: rtl/noc_apb_ni_completer.sv
// rtl/noc_apb_ni_completer.sv - mesh NI endpoint that executes APB request packets and returns responses
module noc_apb_ni_completer #(
   parameter int ROUTER_ROW     = 0,
   parameter int ROUTER_COL     = 0,
   parameter int GRID_WIDTH     = 4,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 16,
   localparam int COORD_W          = $clog2(GRID_WIDTH),
   localparam int APB_PACKET_WIDTH = 68 + 4 * COORD_W
) (
   input  logic                        i_clk,
   input  logic                        i_srst,
   input  logic [APB_PACKET_WIDTH-1:0] i_pktFromRouter,
   output logic [APB_PACKET_WIDTH-1:0] o_pktToRouter,
   output logic                        o_psel,
   output logic                        o_penable,
   output logic                        o_pwrite,
   output logic [31:0]                 o_paddr,
   output logic [31:0]                 o_pwdata,
   input  logic                        i_pready,
   input  logic [31:0]                 i_prdata,
   input  logic                        i_pslverr,
   output logic [7:0]                  o_dropCount
);

   localparam int WRITE_BIT    = 64;
   localparam int SRC_COL_LSB  = 65;
   localparam int SRC_ROW_LSB  = 65 + COORD_W;
   localparam int DEST_COL_LSB = 65 + 2 * COORD_W;
   localparam int DEST_ROW_LSB = 65 + 3 * COORD_W;
   localparam int IS_RESP_BIT  = 65 + 4 * COORD_W;
   localparam int ERR_BIT      = 66 + 4 * COORD_W;
   localparam int VALID_BIT    = 67 + 4 * COORD_W;
   // Buffered request keeps data, addr, write and the source coordinates only
   localparam int REQ_W        = 65 + 2 * COORD_W;
   localparam int PTR_W        = $clog2(FIFO_DEPTH);
   localparam int CNT_W        = $clog2(TIMEOUT_CYCLES);

   localparam logic [COORD_W-1:0] MY_ROW   = COORD_W'(ROUTER_ROW);
   localparam logic [COORD_W-1:0] MY_COL   = COORD_W'(ROUTER_COL);
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} stateType;

   stateType                    state, stateNext;
   logic [REQ_W-1:0]            fifoMem [FIFO_DEPTH];
   logic [REQ_W-1:0]            headReq;
   logic [PTR_W:0]              wrPtr, rdPtr;
   logic [2*COORD_W-1:0]        curSrc;
   logic [CNT_W-1:0]            waitCnt;
   logic [APB_PACKET_WIDTH-1:0] respPkt;
   logic                        pktForUs, fifoEmpty, fifoFull;
   logic                        pop, push, drop, timeoutHit;
   logic                        unusedErrBit;

   assign unusedErrBit = i_pktFromRouter[ERR_BIT];
   assign headReq      = fifoMem[rdPtr[PTR_W-1:0]];
   assign fifoEmpty    = (wrPtr == rdPtr);
   assign fifoFull     = (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]) && (wrPtr[PTR_W] != rdPtr[PTR_W]);
   assign pktForUs     = i_pktFromRouter[VALID_BIT] && !i_pktFromRouter[IS_RESP_BIT]
                         && (i_pktFromRouter[DEST_ROW_LSB +: COORD_W] == MY_ROW)
                         && (i_pktFromRouter[DEST_COL_LSB +: COORD_W] == MY_COL);
   assign pop          = (state == IDLE) && !fifoEmpty;
   // A full buffer still takes a packet when the head leaves on the same edge
   assign push         = pktForUs && (!fifoFull || pop);
   assign drop         = i_pktFromRouter[VALID_BIT] && !push;

   // FSM state register
   always_ff @(posedge i_clk) begin
      if (i_srst) state <= IDLE;
      else        state <= stateNext;
   end

   // Next-state logic; the ready check wins over the timeout on the last wait cycle
   always_comb begin
      stateNext  = state;
      timeoutHit = 1'b0;
      case (state)
         IDLE:    if (!fifoEmpty) stateNext = SETUP;
         SETUP:   stateNext = ACCESS;
         ACCESS: begin
            if (i_pready) begin
               stateNext = RESP;
            end else if (waitCnt == CNT_LAST) begin
               stateNext  = RESP;
               timeoutHit = 1'b1;
            end
         end
         RESP:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Response packet assembled from the request still held on the APB outputs
   always_comb begin
      respPkt                                = '0;
      respPkt[VALID_BIT]                     = 1'b1;
      respPkt[ERR_BIT]                       = timeoutHit || (i_pready && i_pslverr);
      respPkt[IS_RESP_BIT]                   = 1'b1;
      respPkt[DEST_ROW_LSB +: COORD_W]       = curSrc[COORD_W +: COORD_W];
      respPkt[DEST_COL_LSB +: COORD_W]       = curSrc[0 +: COORD_W];
      respPkt[SRC_ROW_LSB +: COORD_W]        = MY_ROW;
      respPkt[SRC_COL_LSB +: COORD_W]        = MY_COL;
      respPkt[WRITE_BIT]                     = o_pwrite;
      respPkt[63:32]                         = o_paddr;
      respPkt[31:0]                          = (o_pwrite || timeoutHit) ? 32'h0 : i_prdata;
   end

   // Request buffer storage, no reset needed since pointers define validity
   always_ff @(posedge i_clk) begin
      if (push) fifoMem[wrPtr[PTR_W-1:0]] <= i_pktFromRouter[REQ_W-1:0];
   end

   // Pointers, drop counter, wait counter and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         wrPtr         <= '0;
         rdPtr         <= '0;
         curSrc        <= '0;
         waitCnt       <= '0;
         o_dropCount   <= '0;
         o_psel        <= 1'b0;
         o_penable     <= 1'b0;
         o_pwrite      <= 1'b0;
         o_paddr       <= '0;
         o_pwdata      <= '0;
         o_pktToRouter <= '0;
      end else begin
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
         if (drop && (o_dropCount != 8'hFF)) o_dropCount <= o_dropCount + 8'd1;
         if ((state == ACCESS) && (stateNext == ACCESS)) waitCnt <= waitCnt + 1'b1;
         else                                            waitCnt <= '0;
         o_psel    <= (stateNext == SETUP) || (stateNext == ACCESS);
         o_penable <= (stateNext == ACCESS);
         if (pop) begin
            curSrc   <= headReq[SRC_COL_LSB +: 2*COORD_W];
            o_pwrite <= headReq[WRITE_BIT];
            o_paddr  <= headReq[63:32];
            o_pwdata <= headReq[31:0];
         end else if ((stateNext != SETUP) && (stateNext != ACCESS)) begin
            o_pwrite <= 1'b0;
            o_paddr  <= '0;
            o_pwdata <= '0;
         end
         o_pktToRouter <= ((state == ACCESS) && (stateNext == RESP)) ? respPkt : '0;
      end
   end

endmodule
